uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, second generation of the team's serial TX block. Serialises one frame per accepted word: start bit, DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS stop bits. Bit timing comes from an external baud_tick strobe at OVERSAMPLE× the baud rate; the block contains no divider. Sits between a byte source (FIFO or CPU register) and the pad.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9
STOP_BITS, 1, stop bits per frame; legal values 1 or 2
OVERSAMPLE, 16, baud_tick strobes per bit period; legal range 4..64

Ports:
clk  in  1  single system clock; all logic on the rising edge
rst  in  1  asynchronous, active-high reset
baud_tick  in  1  one-clk strobe at OVERSAMPLE× baud rate
valid_in  in  1  source has a word on data_in
data_in  in  DATA_BITS  word to send
parity_mode  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none)
ready_out  out  1  block can accept a word this cycle
tx  out  1  serial line, idle high
busy  out  1  frame in progress
tx_done  out  1  one-clk pulse when the last stop bit completes

Behaviour:
- Reset (async assert, sync release): state IDLE, tx=1, ready_out=1, busy=0, tx_done=0, all counters and the shift register 0.
- ready_out = (state==IDLE). Transfer occurs on a clk edge with valid_in && ready_out. data_in and parity_mode are captured at that edge. Parity is computed from the captured data: even → XOR of the bits; odd → inverted XOR.
- States: IDLE → START → DATA → PARITY (only if the captured mode is 01 or 10) → STOP → IDLE.
- tx is registered. It drives 0 from the clk after the transfer edge.
- tick_cnt (width $clog2(OVERSAMPLE)) increments only on baud_tick. Each bit ends on the baud_tick where tick_cnt==OVERSAMPLE-1; tick_cnt then wraps to 0 and the next bit is driven on the next clk.
- The start bit may be up to one tick period short of OVERSAMPLE ticks, because the transfer edge is not aligned to baud_tick. This is accepted.
- DATA: tx = shift_reg[0]. At the end of each bit, shift right and increment bit_cnt (width $clog2(DATA_BITS+1)). After DATA_BITS bits, go to PARITY or STOP.
- STOP: tx=1 for STOP_BITS×OVERSAMPLE ticks, using a stop-bit counter.
- Last stop tick: go to IDLE and pulse tx_done for exactly one clk. ready_out is 1 in that same cycle.
- No inter-frame gap is inserted. A word with valid_in high during the tx_done cycle is accepted immediately, and its start bit follows on the next clk.
- busy = !ready_out.
- valid_in outside IDLE is ignored, and the source must hold its word.
- No baud_tick: the state holds indefinitely and tx holds its level.
- Reset mid-frame: tx=1 and ready_out=1 immediately (async). The partial frame is abandoned and no tx_done pulse is produced.
- Changes to parity_mode mid-frame have no effect until the next capture.

Optional Feature:
UART_TX_BREAK_EN. When defined, the block adds an input port break_req (1 bit):
- break_req high while in IDLE enters state BREAK: tx=0, ready_out=0, busy=1.
- BREAK lasts as long as break_req is high and for at least (DATA_BITS+3)×OVERSAMPLE ticks.
- On exit, the line is held at tx=1 for one full bit period, then the block returns to IDLE. No tx_done pulse is produced.
- break_req asserted mid-frame is deferred until the frame completes.
When not defined: no break_req port and no BREAK state; the behaviour is exactly as above.

Decomposition:
- Shared package uart_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, BREAK
  - parity_mode localparams: PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10
  - reused by the future uart_rx_cfg.
- The sub-module uart_baud_gen (accumulator divider producing baud_tick) lives outside this block and is instanced alongside it at the uart top. uart_tx_cfg itself is a single module with no children.

Test Plan:
- OVERSAMPLE=16, baud_tick=1 every clk, parity 00, send 8'hA5 → tx bits 0,1,0,1,0,0,1,0,1,1, each 16 clk; tx_done 160 clk after the start bit begins; ready_out=1 in the same cycle.
- Parity 01, send 8'h07 → parity bit 1, frame 11 bits; parity 10, send 8'h07 → parity bit 0.
- Tick every 4 clk, STOP_BITS=2, send 8'h00 → each bit 64 clk; stop high 128 clk.
- valid_in held high with 8'h3C then 8'h81 → second start bit immediately after the tx_done cycle; no idle gap; both frames bit-exact.
- rst pulsed during data bit 3 → tx=1 and ready_out=1 within the same cycle; no tx_done; the next send of 8'hFF is a clean frame.
- UART_TX_BREAK_EN defined, break_req high for 10 clk in IDLE at 1 tick/clk → tx low for 176 clk, then high for 16 clk, then ready_out=1.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and constants for the UART TX/RX blocks.
// Revision: 2.0 - second-generation serial block, shared with uart_rx_cfg
// ============================================================================
`default_nettype none

package uart_pkg;

  // Frame sequencer states (BREAK only reachable when break support is built in)
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  // parity_mode encodings; 2'b11 is reserved and behaves as no parity
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/uart_tx_cfg.sv
// ============================================================================
// Module  : uart_tx_cfg
// Brief   : Parametrised UART transmitter. Start bit, DATA_BITS data bits
//           LSB first, optional parity, STOP_BITS stop bits. Bit timing from
//           an external baud_tick strobe at OVERSAMPLE x baud.
//           Optional macro UART_TX_BREAK_EN adds break_req and a BREAK state.
// Revision: 2.0 - second generation TX block
// ============================================================================
`default_nettype none

module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [1:0]           parity_mode,
`ifdef UART_TX_BREAK_EN
  input  logic                 break_req,
`endif
  output logic                 ready_out,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]           stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 w_bit_end;

`ifdef UART_TX_BREAK_EN
  // Break must cover at least DATA_BITS+3 bit periods; counted in bit units
  localparam int KW = $clog2(DATA_BITS + 3);
  localparam logic [KW-1:0] BRK_LAST = KW'(DATA_BITS + 2);
  logic [KW-1:0] brk_cnt_q, brk_cnt_d;
  logic          brk_min_q, brk_min_d;
  logic          brk_rel_q, brk_rel_d;
  logic          w_brk_min;
`endif

  // A bit period ends on the baud tick that completes OVERSAMPLE ticks
  assign w_bit_end = baud_tick && (tick_cnt_q == TICK_LAST);

  // State and datapath registers; tx idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q  <= '0;
      brk_min_q  <= 1'b0;
      brk_rel_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q  <= brk_cnt_d;
      brk_min_q  <= brk_min_d;
      brk_rel_q  <= brk_rel_d;
`endif
    end
  end

  // Next-state logic: capture on transfer, advance per completed bit period
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`ifdef UART_TX_BREAK_EN
    brk_cnt_d  = brk_cnt_q;
    brk_min_d  = brk_min_q;
    brk_rel_d  = brk_rel_q;
    w_brk_min  = 1'b0;
`endif
    if (state_q != IDLE && baud_tick) begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        // Tick count starts fresh so each frame's bit grid begins at transfer
        tick_cnt_d = '0;
        if (valid_in) begin
          state_d    = START;
          shift_d    = data_in;
          bit_cnt_d  = '0;
          stop_cnt_d = '0;
          case (parity_mode)
            PAR_EVEN: begin par_en_d = 1'b1; par_bit_d = ^data_in;    end
            PAR_ODD:  begin par_en_d = 1'b1; par_bit_d = ~(^data_in); end
            PAR_NONE: begin par_en_d = 1'b0; par_bit_d = 1'b0;        end
            default:  begin par_en_d = 1'b0; par_bit_d = 1'b0;        end
          endcase
        end
`ifdef UART_TX_BREAK_EN
        else if (break_req) begin
          state_d   = BREAK;
          brk_cnt_d = '0;
          brk_min_d = 1'b0;
          brk_rel_d = 1'b0;
        end
`endif
      end
      START: begin
        if (w_bit_end) state_d = DATA;
      end
      DATA: begin
        if (w_bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (w_bit_end) state_d = STOP;
      end
      STOP: begin
        if (w_bit_end) begin
          if (stop_cnt_q == STOP_LAST) state_d = IDLE;
          else                         stop_cnt_d = stop_cnt_q + 2'd1;
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (!brk_rel_q) begin
          // Low phase: runs until the minimum length is met and break_req drops
          if (w_bit_end && brk_cnt_q != BRK_LAST) brk_cnt_d = brk_cnt_q + 1'b1;
          w_brk_min = brk_min_q || (w_bit_end && brk_cnt_q == BRK_LAST);
          if (w_brk_min && !break_req) begin
            brk_rel_d  = 1'b1;
            tick_cnt_d = '0;
          end else if (w_brk_min) begin
            brk_min_d = 1'b1;
          end
        end else if (w_bit_end) begin
          // One full high bit period after the break, then back to idle
          state_d   = IDLE;
          brk_rel_d = 1'b0;
          brk_min_d = 1'b0;
          brk_cnt_d = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output logic: registered line level follows the upcoming state
  always_comb begin
    done_d = (state_q == STOP) && (state_d == IDLE);
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      STOP:    tx_d = 1'b1;
`ifdef UART_TX_BREAK_EN
      BREAK:   tx_d = brk_rel_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign tx_done   = done_q;
  assign ready_out = (state_q == IDLE);
  assign busy      = ~ready_out;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
// ============================================================================
// Module  : tb_uart_tx_cfg
// Brief   : Directed self-checking bench for uart_tx_cfg (default build and,
//           when UART_TX_BREAK_EN is defined, the break sequence).
// Revision: 2.0
// ============================================================================
`default_nettype none

module tb_uart_tx_cfg;

  logic       clk;
  logic       rst;
  logic       tick1;
  logic       tick4;
  logic [1:0] div;
  logic       valid_in;
  logic       valid2;
  logic [7:0] data_in;
  logic [1:0] parity_mode;
  logic       ready_out, tx, busy, tx_done;
  logic       ready2, tx2, busy2, done2;
`ifdef UART_TX_BREAK_EN
  logic       break_req;
`endif

  int n_cmp;
  int n_fail;

  uart_tx_cfg #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (tick1),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .parity_mode(parity_mode),
`ifdef UART_TX_BREAK_EN
    .break_req  (break_req),
`endif
    .ready_out  (ready_out),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  uart_tx_cfg #(.DATA_BITS(8), .STOP_BITS(2), .OVERSAMPLE(16)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (tick4),
    .valid_in   (valid2),
    .data_in    (data_in),
    .parity_mode(2'b00),
`ifdef UART_TX_BREAK_EN
    .break_req  (1'b0),
`endif
    .ready_out  (ready2),
    .tx         (tx2),
    .busy       (busy2),
    .tx_done    (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle baud strobe every 4 clocks, changing on the falling edge
  initial begin div = 2'd0; tick4 = 1'b0; end
  always @(negedge clk) begin
    div   = div + 2'd1;
    tick4 = (div == 2'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after the transfer edge; exp[k] is frame bit k (bit 0 = start)
  task automatic frame_check(input logic [15:0] exp, input int nb, input string tag,
                             input bit hold, input logic [7:0] nxt);
    for (int n = 1; n <= nb * 16 + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk({tag, " start immediate"}, {31'd0, tx}, 32'd0);
        if (!hold) valid_in = 1'b0;
        parity_mode = 2'b00;
      end
      if (n == nb * 16) data_in = nxt;
      if (n % 16 == 8) chk($sformatf("%s bit%0d", tag, n / 16), {31'd0, tx}, {31'd0, exp[n / 16]});
      if (n == nb * 16) chk({tag, " no early done"}, {31'd0, tx_done}, 32'd0);
      if (n == nb * 16 + 1) begin
        chk({tag, " tx_done"}, {31'd0, tx_done}, 32'd1);
        chk({tag, " ready at done"}, {31'd0, ready_out}, 32'd1);
      end
    end
  endtask

  task automatic send_check(input logic [7:0] d, input logic [1:0] m, input logic [15:0] exp,
                            input int nb, input string tag);
    @(negedge clk);
    data_in = d; parity_mode = m; valid_in = 1'b1;
    @(posedge clk);
    frame_check(exp, nb, tag, 1'b0, d);
  endtask

  initial begin
    int  low_len, high_len;
    bit  saw_done, saw_low;
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; tick1 = 1'b1; valid_in = 1'b0; valid2 = 1'b0;
    data_in = 8'h00; parity_mode = 2'b00;
`ifdef UART_TX_BREAK_EN
    break_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset tx", {31'd0, tx}, 32'd1);
    chk("reset ready", {31'd0, ready_out}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, tx_done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 8'hA5, no parity: 0,1,0,1,0,0,1,0,1,1
    send_check(8'hA5, 2'b00, 16'h034A, 10, "A5 none");
    // 8'h07 even parity: parity bit 1; odd parity: parity bit 0
    send_check(8'h07, 2'b01, 16'h060E, 11, "07 even");
    send_check(8'h07, 2'b10, 16'h040E, 11, "07 odd");

    // Back-to-back: valid held, second word accepted in the tx_done cycle
    @(negedge clk);
    data_in = 8'h3C; parity_mode = 2'b00; valid_in = 1'b1;
    @(posedge clk);
    frame_check(16'h0278, 10, "3C b2b", 1'b1, 8'h81);
    frame_check(16'h0302, 10, "81 b2b", 1'b0, 8'h81);

    // Reset during data bit 3 (frame bit 4)
    @(negedge clk);
    data_in = 8'hA5; valid_in = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 72; n++) begin
      @(negedge clk);
      if (n == 1) valid_in = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midrst tx", {31'd0, tx}, 32'd1);
    chk("midrst ready", {31'd0, ready_out}, 32'd1);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0; saw_low = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx_done) saw_done = 1'b1;
      if (!tx) saw_low = 1'b1;
    end
    chk("midrst no done", {31'd0, saw_done}, 32'd0);
    chk("midrst line idle", {31'd0, saw_low}, 32'd0);
    send_check(8'hFF, 2'b00, 16'h03FE, 10, "FF after rst");

    // Tick every 4 clk, two stop bits, 8'h00: low 9*64 clk, stop high 128 clk
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (tick4) break;
    end
    data_in = 8'h00; valid2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid2 = 1'b0;
    low_len = 0;
    while (tx2 === 1'b0 && low_len < 2000) begin
      low_len++;
      @(negedge clk);
    end
    high_len = 0;
    while (done2 !== 1'b1 && high_len < 1000) begin
      high_len++;
      @(negedge clk);
    end
    chk("slow low length", low_len, 32'd576);
    chk("slow stop length", high_len, 32'd128);
    chk("slow done", {31'd0, done2}, 32'd1);
    chk("slow ready", {31'd0, ready2}, 32'd1);

`ifdef UART_TX_BREAK_EN
    // break_req high 10 clk: low 176 clk, high 16 clk, then idle
    @(negedge clk);
    break_req = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 193; n++) begin
      @(negedge clk);
      if (n == 10) break_req = 1'b0;
      if (n == 1) chk("brk busy", {31'd0, busy}, 32'd1);
      if (n == 176) chk("brk low end", {31'd0, tx}, 32'd0);
      if (n == 177) chk("brk release", {31'd0, tx}, 32'd1);
      if (n == 192) chk("brk not ready", {31'd0, ready_out}, 32'd0);
      if (n == 193) begin
        chk("brk ready", {31'd0, ready_out}, 32'd1);
        chk("brk no done", {31'd0, tx_done}, 32'd0);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
